// File: rtl/ac97_frame_tx.sv
// ac97_frame_tx: AC-link output-frame serializer for the Game Boy sound path.
//
// Runs on BIT_CLK. Every 256 clocks it sends one SYNC/SDATA_OUT frame that
// carries stereo PCM in slots 3/4 and, when a command is waiting, one codec
// register write in slots 1/2. It also gives the sound controller a
// once-per-frame strobe at the point where the samples are latched.
//
// Optional feature macro: AC97_AUTO_INIT_EN
//   When defined, two codec writes follow warmup before the link is declared
//   up: 0x02 <- 0x0000 (master unmute), then 0x18 <- 0x0808 (PCM out gain).
//   When undefined, warmup goes straight to normal operation.
//
// Ports:
//   I_CLK        in   AC-link BIT_CLK, the only clock
//   I_RESET      in   asynchronous active-high reset
//   I_SO1[19:0]  in   right-channel sample (slot 4)
//   I_SO2[19:0]  in   left-channel sample (slot 3)
//   I_CMD_VALID  in   codec register write request
//   I_CMD_ADDR   in   codec register address
//   I_CMD_DATA   in   codec register data
//   O_CMD_READY  out  command holding register can accept a write
//   O_SYNC       out  AC-link SYNC, high for bits c=0..15
//   O_SDATA_OUT  out  AC-link serial data, frame bit n in cycle c=n+1
//   O_STROBE     out  one-cycle pulse in c=0 (sample latch point)
//   O_LINK_UP    out  warmup (and auto-init, if built) complete
//
// State | meaning
// ------+----------------------------------------------------------------
// WARMUP| all-zero tag and slots, lasts WARMUP_FRAMES frames
// INIT  | auto-init register writes (only with AC97_AUTO_INIT_EN)
// RUN   | frame valid, PCM slots 3/4 valid, slots 1/2 from holding register

module ac97_frame_tx #(
  parameter int WARMUP_FRAMES = 4
) (
  input  logic        I_CLK,
  input  logic        I_RESET,
  input  logic [19:0] I_SO1,
  input  logic [19:0] I_SO2,
  input  logic        I_CMD_VALID,
  input  logic [6:0]  I_CMD_ADDR,
  input  logic [15:0] I_CMD_DATA,
  output logic        O_CMD_READY,
  output logic        O_SYNC,
  output logic        O_SDATA_OUT,
  output logic        O_STROBE,
  output logic        O_LINK_UP
);

  localparam int WU_W = (WARMUP_FRAMES > 1) ? $clog2(WARMUP_FRAMES) : 1;
  localparam logic [WU_W-1:0] WU_LOAD = WU_W'(WARMUP_FRAMES - 1);

  // Tag bit positions within the 16-bit tag word (bit 15 is sent first).
  localparam int TAG_FRAME = 15;
  localparam int TAG_SLOT1 = 14;
  localparam int TAG_SLOT2 = 13;
  localparam int TAG_SLOT3 = 12;
  localparam int TAG_SLOT4 = 11;

  typedef enum logic [1:0] {
    ST_WARMUP = 2'd0,
    ST_INIT   = 2'd1,
    ST_RUN    = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_started;
  logic [7:0]        r_cnt;
  logic [WU_W-1:0]   r_wu_cnt;
  logic              r_hold_full;
  logic [6:0]        r_hold_addr;
  logic [15:0]       r_hold_data;
  logic [94:0]       r_shift;
`ifdef AC97_AUTO_INIT_EN
  logic              r_init_idx;
  logic [6:0]        w_init_addr;
  logic [15:0]       w_init_data;
`endif

  logic [7:0]  w_cnt_nxt;
  logic        w_build;
  logic        w_frame_end;
  logic        w_consume;
  logic        w_accept;
  logic        w_hold_nxt;
  logic        w_enter_run;
  logic        w_link_nxt;
  logic [15:0] w_tag;
  logic [19:0] w_slot1;
  logic [19:0] w_slot2;
  logic [19:0] w_slot3;
  logic [19:0] w_slot4;
  logic [95:0] w_frame;

  // The first clock after reset release lands on c=0 rather than c=1, so the
  // counter only starts advancing once r_started is set.
  assign w_cnt_nxt   = r_started ? (r_cnt + 8'd1) : 8'd0;
  assign w_build     = r_started && (r_cnt == 8'd0);
  assign w_frame_end = r_started && (r_cnt == 8'd255);

  // Readiness is the registered value, so a full holding register blocks a
  // request in c=0 even though it is emptied at the end of that same cycle.
  assign w_accept   = I_CMD_VALID && O_CMD_READY;
  assign w_consume  = w_build && (r_state == ST_RUN) && r_hold_full;
  assign w_hold_nxt = (r_hold_full && !w_consume) || w_accept;

`ifdef AC97_AUTO_INIT_EN
  assign w_init_addr = r_init_idx ? 7'h18 : 7'h02;
  assign w_init_data = r_init_idx ? 16'h0808 : 16'h0000;
  assign w_enter_run = w_frame_end && (r_state == ST_INIT) && r_init_idx;
`else
  assign w_enter_run = w_frame_end && (r_state == ST_WARMUP) && (r_wu_cnt == '0);
`endif
  assign w_link_nxt = O_LINK_UP || w_enter_run;

  always_comb begin
    w_tag   = '0;
    w_slot1 = '0;
    w_slot2 = '0;
    w_slot3 = '0;
    w_slot4 = '0;
    case (r_state)
`ifdef AC97_AUTO_INIT_EN
      ST_INIT: begin
        w_tag[TAG_FRAME] = 1'b1;
        w_tag[TAG_SLOT1] = 1'b1;
        w_tag[TAG_SLOT2] = 1'b1;
        w_tag[TAG_SLOT3] = 1'b1;
        w_tag[TAG_SLOT4] = 1'b1;
        w_slot1 = {1'b0, w_init_addr, 12'h000};
        w_slot2 = {w_init_data, 4'h0};
        w_slot3 = I_SO2;
        w_slot4 = I_SO1;
      end
`endif
      ST_RUN: begin
        w_tag[TAG_FRAME] = 1'b1;
        w_tag[TAG_SLOT3] = 1'b1;
        w_tag[TAG_SLOT4] = 1'b1;
        w_slot3 = I_SO2;
        w_slot4 = I_SO1;
        if (r_hold_full) begin
          w_tag[TAG_SLOT1] = 1'b1;
          w_tag[TAG_SLOT2] = 1'b1;
          w_slot1 = {1'b0, r_hold_addr, 12'h000};
          w_slot2 = {r_hold_data, 4'h0};
        end
      end
      default: ;
    endcase
  end

  // Bits 96..255 of the frame are always zero, so only 96 bits are built;
  // the shift register fills with zeros behind them.
  assign w_frame = {w_tag, w_slot1, w_slot2, w_slot3, w_slot4};

  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      r_state     <= ST_WARMUP;
      r_started   <= 1'b0;
      r_cnt       <= 8'd0;
      r_wu_cnt    <= WU_LOAD;
      r_hold_full <= 1'b0;
      r_hold_addr <= '0;
      r_hold_data <= '0;
      r_shift     <= '0;
`ifdef AC97_AUTO_INIT_EN
      r_init_idx  <= 1'b0;
`endif
      O_SYNC      <= 1'b0;
      O_SDATA_OUT <= 1'b0;
      O_STROBE    <= 1'b0;
      O_CMD_READY <= 1'b0;
      O_LINK_UP   <= 1'b0;
    end else begin
      r_started <= 1'b1;
      r_cnt     <= w_cnt_nxt;
      O_SYNC    <= (w_cnt_nxt < 8'd16);
      O_STROBE  <= (w_cnt_nxt == 8'd0);

      // Loading at the end of c=0 puts frame bit 0 on the wire in c=1.
      if (w_build) begin
        {O_SDATA_OUT, r_shift} <= w_frame;
      end else begin
        {O_SDATA_OUT, r_shift} <= {r_shift, 1'b0};
      end

      r_hold_full <= w_hold_nxt;
      if (w_accept) begin
        r_hold_addr <= I_CMD_ADDR;
        r_hold_data <= I_CMD_DATA;
      end

      O_LINK_UP   <= w_link_nxt;
      O_CMD_READY <= w_link_nxt && !w_hold_nxt;

      if (w_frame_end) begin
        case (r_state)
          ST_WARMUP: begin
            if (r_wu_cnt == '0) begin
`ifdef AC97_AUTO_INIT_EN
              r_state    <= ST_INIT;
              r_init_idx <= 1'b0;
`else
              r_state    <= ST_RUN;
`endif
            end else begin
              r_wu_cnt <= r_wu_cnt - 1'b1;
            end
          end
`ifdef AC97_AUTO_INIT_EN
          ST_INIT: begin
            if (r_init_idx) begin
              r_state <= ST_RUN;
            end else begin
              r_init_idx <= 1'b1;
            end
          end
`endif
          ST_RUN:  r_state <= ST_RUN;
          default: r_state <= ST_WARMUP;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ac97_frame_tx.sv
// Testbench for ac97_frame_tx: expected frames are queued as each frame is
// built and compared against the serialized bits when the frame completes.
module tb_ac97_frame_tx;

  localparam int WU = 4;
`ifdef AC97_AUTO_INIT_EN
  localparam int LINK_F = WU + 2;
`else
  localparam int LINK_F = WU;
`endif

  logic        clk;
  logic        I_RESET;
  logic [19:0] I_SO1;
  logic [19:0] I_SO2;
  logic        I_CMD_VALID;
  logic [6:0]  I_CMD_ADDR;
  logic [15:0] I_CMD_DATA;
  logic        O_CMD_READY;
  logic        O_SYNC;
  logic        O_SDATA_OUT;
  logic        O_STROBE;
  logic        O_LINK_UP;

  ac97_frame_tx #(.WARMUP_FRAMES(WU)) dut (
    .I_CLK       (clk),
    .I_RESET     (I_RESET),
    .I_SO1       (I_SO1),
    .I_SO2       (I_SO2),
    .I_CMD_VALID (I_CMD_VALID),
    .I_CMD_ADDR  (I_CMD_ADDR),
    .I_CMD_DATA  (I_CMD_DATA),
    .O_CMD_READY (O_CMD_READY),
    .O_SYNC      (O_SYNC),
    .O_SDATA_OUT (O_SDATA_OUT),
    .O_STROBE    (O_STROBE),
    .O_LINK_UP   (O_LINK_UP)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  logic [95:0] exp_q[$];

  // Bench view of the link: cycle/frame position and holding register.
  int          c_now = -1;
  int          f_now = -1;
  bit          e_link = 0;
  bit          e_hold = 0;
  logic [6:0]  e_haddr = '0;
  logic [15:0] e_hdata = '0;
  int          rdy_bad = 0;
  int          link_bad = 0;

  function automatic logic [95:0] exp_frame(input int f, input logic [19:0] so1,
                                            input logic [19:0] so2, input bit hold,
                                            input logic [6:0] a, input logic [15:0] d);
    if (f < WU) return '0;
`ifdef AC97_AUTO_INIT_EN
    if (f == WU)     return {16'hF800, 1'b0, 7'h02, 12'h000, 16'h0000, 4'h0, so2, so1};
    if (f == WU + 1) return {16'hF800, 1'b0, 7'h18, 12'h000, 16'h0808, 4'h0, so2, so1};
`endif
    if (hold) return {16'hF800, 1'b0, a, 12'h000, d, 4'h0, so2, so1};
    return {16'h9800, 20'h0, 20'h0, so2, so1};
  endfunction

  task automatic step();
    bit rdy_b;
    rdy_b = e_link && !e_hold;
    if (O_CMD_READY !== rdy_b) rdy_bad++;
    if (O_LINK_UP !== e_link) link_bad++;
    if (c_now == 255) begin
      check_val("ready_track", 96'(rdy_bad), 96'd0);
      check_val("linkup_track", 96'(link_bad), 96'd0);
      rdy_bad = 0;
      link_bad = 0;
    end
    if (c_now == 0) begin
      exp_q.push_back(exp_frame(f_now, I_SO1, I_SO2, e_hold, e_haddr, e_hdata));
      if (f_now >= LINK_F) e_hold = 0;
    end
    if (I_CMD_VALID && rdy_b) begin
      e_hold  = 1;
      e_haddr = I_CMD_ADDR;
      e_hdata = I_CMD_DATA;
    end
    @(posedge clk);
    #2;
    c_now = (c_now == 255) ? 0 : c_now + 1;
    if (c_now == 0) f_now++;
    e_link = (f_now >= LINK_F);
  endtask

  task automatic run_to(input int f, input int c);
    int guard;
    guard = 0;
    while (!(f_now == f && c_now == c)) begin
      step();
      guard++;
      if (guard > 20000) begin
        check_val("run_to_timeout", 96'd1, 96'd0);
        break;
      end
    end
  endtask

  task automatic bench_reset_state();
    c_now = -1;
    f_now = -1;
    e_link = 0;
    e_hold = 0;
    rdy_bad = 0;
    link_bad = 0;
    exp_q.delete();
  endtask

  // Frame monitor, sampling mid-cycle on the falling edge.
  logic [95:0] cap;
  int  sync_bad, strb_bad, zero_bad;
  bit  mon_on = 0;

  always @(negedge clk) begin
    if (I_RESET || c_now < 0) begin
      mon_on = 0;
    end else begin
      if (c_now == 0) begin
        mon_on   = 1;
        cap      = '0;
        sync_bad = 0;
        strb_bad = 0;
        zero_bad = 0;
      end
      if (mon_on) begin
        if (O_SYNC !== (c_now < 16)) sync_bad++;
        if (O_STROBE !== (c_now == 0)) strb_bad++;
        if (c_now >= 1 && c_now <= 96) cap = {cap[94:0], O_SDATA_OUT};
        else if (O_SDATA_OUT !== 1'b0) zero_bad++;
        if (c_now == 255) begin
          check_val("sync_pattern", 96'(sync_bad), 96'd0);
          check_val("strobe_pattern", 96'(strb_bad), 96'd0);
          check_val("zero_bits", 96'(zero_bad), 96'd0);
          if (exp_q.size() == 0) check_val("sb_empty", 96'd1, 96'd0);
          else check_val($sformatf("frame%0d", f_now), cap, exp_q.pop_front());
          mon_on = 0;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  int f1;

  initial begin
    I_RESET = 1'b1;
    I_SO1 = '0;
    I_SO2 = '0;
    I_CMD_VALID = 1'b0;
    I_CMD_ADDR = '0;
    I_CMD_DATA = '0;
    bench_reset_state();
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_outs", 96'({O_SYNC, O_SDATA_OUT, O_STROBE, O_CMD_READY, O_LINK_UP}), 96'd0);
    @(negedge clk);
    I_RESET = 1'b0;

    step();
    check_val("first_sync", 96'(O_SYNC), 96'd1);
    check_val("first_strobe", 96'(O_STROBE), 96'd1);
    check_val("first_ready", 96'(O_CMD_READY), 96'd0);

    run_to(LINK_F - 1, 255);
    check_val("link_before", 96'(O_LINK_UP), 96'd0);
    step();
    check_val("link_rise", 96'(O_LINK_UP), 96'd1);
    check_val("ready_rise", 96'(O_CMD_READY), 96'd1);

    run_to(LINK_F, 200);
    I_SO2 = 20'hA5A5A;
    I_SO1 = 20'h5A5A5;
    for (int k = 0; k < 2; k++) begin
      run_to(LINK_F + 1 + k, 200);
      I_SO1 = 20'($urandom());
      I_SO2 = 20'($urandom());
    end

    f1 = LINK_F + 3;
    run_to(f1, 100);
    I_SO1 = 20'h80000;
    I_SO2 = 20'h7FFFF;
    check_val("ready_pre_cmd", 96'(O_CMD_READY), 96'd1);
    I_CMD_VALID = 1'b1;
    I_CMD_ADDR  = 7'h02;
    I_CMD_DATA  = 16'h1234;
    step();
    I_CMD_VALID = 1'b0;
    check_val("ready_after_acc", 96'(O_CMD_READY), 96'd0);

    run_to(f1 + 1, 0);
    check_val("ready_c0_full", 96'(O_CMD_READY), 96'd0);
    I_CMD_VALID = 1'b1;
    I_CMD_ADDR  = 7'h18;
    I_CMD_DATA  = 16'hBEEF;
    step();
    check_val("ready_c1", 96'(O_CMD_READY), 96'd1);
    step();
    I_CMD_VALID = 1'b0;
    check_val("ready_c2_full", 96'(O_CMD_READY), 96'd0);

    run_to(f1 + 3, 0);
    check_val("ready_c0_empty", 96'(O_CMD_READY), 96'd1);
    I_CMD_VALID = 1'b1;
    I_CMD_ADDR  = 7'h26;
    I_CMD_DATA  = 16'hA5C3;
    step();
    I_CMD_VALID = 1'b0;

    run_to(f1 + 5, 130);
    I_RESET = 1'b1;
    bench_reset_state();
    #1;
    check_val("midreset_outs", 96'({O_SYNC, O_SDATA_OUT, O_STROBE, O_CMD_READY, O_LINK_UP}), 96'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    I_RESET = 1'b0;
    step();
    check_val("restart_sync", 96'(O_SYNC), 96'd1);
    check_val("restart_strobe", 96'(O_STROBE), 96'd1);
    check_val("restart_link", 96'(O_LINK_UP), 96'd0);

    run_to(1, 255);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
